// File: rtl/clock_set_ctrl_if.sv
// ============================================================================
//  Module   : clock_set_ctrl_if
//  Purpose  : Button / timekeeper bundle for the clock time-setting controller
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       o_load;
    logic [4:0] o_hours;
    logic [5:0] o_minutes;
    logic [1:0] o_mode;
    logic       o_blink;

    modport master (
        output btn_mode, btn_inc, cur_hours, cur_minutes,
        input  o_load, o_hours, o_minutes, o_mode, o_blink
    );

    modport slave (
        input  btn_mode, btn_inc, cur_hours, cur_minutes,
        output o_load, o_hours, o_minutes, o_mode, o_blink
    );
endinterface

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// ============================================================================
//  Module   : clock_set_ctrl
//  Purpose  : Run / set-hours / set-minutes / commit sequencer with shadow time,
//             auto-repeat increment, inactivity abort and edit-field blink
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_set_ctrl #(
    parameter int TIMEOUT    = 2500,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100,
    parameter int BLINK_PER  = 50
) (
    input  wire logic          clk,
    input  wire logic          rst,
    clock_set_ctrl_if.slave    bus
);

    localparam int IDLE_W  = $clog2(TIMEOUT);
    localparam int HOLD_W  = $clog2(REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER);
    localparam int BLINK_W = $clog2(BLINK_PER + 1);

    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
    localparam logic [HOLD_W-1:0]  DLY_LAST   = HOLD_W'(REPEAT_DLY - 1);
    localparam logic [HOLD_W-1:0]  PER_LAST   = HOLD_W'(REPEAT_PER - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PER - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        COMMIT  = 2'b11
    } state_t;

    state_t              state;
    logic                mode_q;
    logic                inc_q;
    logic                mode_armed;
    logic                inc_armed;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                repeating;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink;
    logic                load;
    logic [4:0]          hours;
    logic [5:0]          minutes;

    logic                mode_rise;
    logic                inc_rise;
    logic                tick;
    logic                inc_evt;
    logic [HOLD_W-1:0]   hold_tgt;

    // A button held through reset must be seen low once before it can rise.
    assign mode_rise = bus.btn_mode & ~mode_q & mode_armed;
    assign inc_rise  = bus.btn_inc  & ~inc_q  & inc_armed;
    assign hold_tgt  = repeating ? PER_LAST : DLY_LAST;
    assign tick      = bus.btn_inc & inc_q & (hold_cnt == hold_tgt);
    assign inc_evt   = inc_rise | tick;

    assign bus.o_load    = load;
    assign bus.o_hours   = hours;
    assign bus.o_minutes = minutes;
    assign bus.o_mode    = state;
    assign bus.o_blink   = blink;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            mode_q     <= 1'b0;
            inc_q      <= 1'b0;
            mode_armed <= 1'b0;
            inc_armed  <= 1'b0;
            idle_cnt   <= '0;
            hold_cnt   <= '0;
            repeating  <= 1'b0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
            load       <= 1'b0;
            hours      <= '0;
            minutes    <= '0;
        end else begin
            mode_q     <= bus.btn_mode;
            inc_q      <= bus.btn_inc;
            mode_armed <= mode_armed | ~bus.btn_mode;
            inc_armed  <= inc_armed  | ~bus.btn_inc;
            load       <= 1'b0;

            case (state)
                RUN: begin
                    idle_cnt  <= '0;
                    hold_cnt  <= '0;
                    repeating <= 1'b0;
                    blink_cnt <= '0;
                    blink     <= 1'b0;
                    if (mode_rise) begin
                        state   <= SET_HR;
                        hours   <= bus.cur_hours;
                        minutes <= bus.cur_minutes;
                        blink   <= 1'b1;
                    end
                end

                SET_HR, SET_MIN: begin
                    if (mode_rise) begin
                        // Mode wins over a coincident increment.
                        idle_cnt  <= '0;
                        hold_cnt  <= '0;
                        repeating <= 1'b0;
                        blink_cnt <= '0;
                        if (state == SET_HR) begin
                            state <= SET_MIN;
                            blink <= 1'b1;
                        end else begin
                            state <= COMMIT;
                            load  <= 1'b1;
                            blink <= 1'b0;
                        end
                    end else begin
                        if (!bus.btn_inc || inc_rise) begin
                            hold_cnt  <= '0;
                            repeating <= 1'b0;
                        end else if (tick) begin
                            hold_cnt  <= '0;
                            repeating <= 1'b1;
                        end else begin
                            hold_cnt  <= hold_cnt + HOLD_W'(1);
                        end

                        if (inc_evt) begin
                            if (state == SET_HR)
                                hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                            else
                                minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                            idle_cnt  <= '0;
                            blink_cnt <= '0;
                            blink     <= 1'b1;
                        end else if (idle_cnt == IDLE_LAST) begin
                            // Abort: shadow values kept, nothing loaded.
                            state     <= RUN;
                            idle_cnt  <= '0;
                            hold_cnt  <= '0;
                            repeating <= 1'b0;
                            blink_cnt <= '0;
                            blink     <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                            if (blink_cnt == BLINK_LAST) begin
                                blink     <= ~blink;
                                blink_cnt <= '0;
                            end else begin
                                blink_cnt <= blink_cnt + BLINK_W'(1);
                            end
                        end
                    end
                end

                COMMIT: begin
                    state     <= RUN;
                    idle_cnt  <= '0;
                    hold_cnt  <= '0;
                    repeating <= 1'b0;
                    blink_cnt <= '0;
                    blink     <= 1'b0;
                end

                default: state <= RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
// ============================================================================
//  Module   : tb_clock_set_ctrl
//  Purpose  : Directed self-checking bench for clock_set_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .TIMEOUT    (20),
        .REPEAT_DLY (8),
        .REPEAT_PER (3),
        .BLINK_PER  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int         load_cnt  = 0;
    int         load_dbl  = 0;
    logic       load_prev = 1'b0;
    logic [4:0] tk_hours  = 5'd0;
    logic [5:0] tk_min    = 6'd0;

    // Timekeeper stand-in: captures the shadow time while load is high.
    always @(negedge clk) begin
        if (bus.o_load === 1'b1) begin
            load_cnt = load_cnt + 1;
            tk_hours = bus.o_hours;
            tk_min   = bus.o_minutes;
            if (load_prev) load_dbl = load_dbl + 1;
        end
        load_prev = (bus.o_load === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        step();
        bus.btn_mode = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_inc = 1'b1;
            step();
            bus.btn_inc = 1'b0;
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int loads_before;

        bus.btn_mode    = 1'b1;
        bus.btn_inc     = 1'b0;
        bus.cur_hours   = 5'd13;
        bus.cur_minutes = 6'd45;

        // Reset with mode held high
        repeat (2) @(posedge clk);
        #1;
        check("rst_mode",    bus.o_mode,    0);
        check("rst_load",    bus.o_load,    0);
        check("rst_hours",   bus.o_hours,   0);
        check("rst_minutes", bus.o_minutes, 0);
        check("rst_blink",   bus.o_blink,   0);
        rst = 1'b1;
        repeat (3) step();
        check("held_mode_no_rise", bus.o_mode, 0);
        bus.btn_mode = 1'b0;
        step();
        check("released_mode", bus.o_mode, 0);

        // Full edit session 13:45 -> 15:01
        press_mode();
        check("s1_mode_hr",   bus.o_mode,    1);
        check("s1_cap_hours", bus.o_hours,   13);
        check("s1_cap_min",   bus.o_minutes, 45);
        check("s1_blink_on",  bus.o_blink,   1);
        press_inc(2);
        check("s1_hours", bus.o_hours, 15);
        press_mode();
        check("s1_mode_min", bus.o_mode, 2);
        press_inc(16);
        check("s1_minutes_wrap", bus.o_minutes, 1);
        check("s1_hours_kept",   bus.o_hours,   15);
        bus.btn_mode = 1'b1;
        step();
        check("s1_mode_commit", bus.o_mode, 3);
        check("s1_load_high",   bus.o_load, 1);
        bus.btn_mode = 1'b0;
        step();
        check("s1_mode_run",   bus.o_mode, 0);
        check("s1_load_low",   bus.o_load, 0);
        check("s1_blink_off",  bus.o_blink, 0);
        check("s1_load_count", load_cnt, 1);
        check("s1_tk_hours",   tk_hours, 15);
        check("s1_tk_min",     tk_min,   1);

        // Hours wrap and simultaneous mode+inc
        bus.cur_hours   = 5'd22;
        bus.cur_minutes = 6'd10;
        press_mode();
        check("s2_cap_hours", bus.o_hours, 22);
        press_inc(1);
        check("s2_inc1", bus.o_hours, 23);
        press_inc(1);
        check("s2_inc2_wrap", bus.o_hours, 0);
        press_inc(1);
        check("s2_inc3", bus.o_hours, 1);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        step();
        check("s2_sim_mode",  bus.o_mode,    2);
        check("s2_sim_hours", bus.o_hours,   1);
        check("s2_sim_min",   bus.o_minutes, 10);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        step();
        press_mode();
        step();
        check("s2_load_count", load_cnt, 2);
        check("s2_tk_hours",   tk_hours, 1);
        check("s2_tk_min",     tk_min,   10);

        // Auto-repeat in SET_MIN from 0
        bus.cur_hours   = 5'd3;
        bus.cur_minutes = 6'd0;
        press_mode();
        press_mode();
        check("s3_mode_min", bus.o_mode, 2);
        check("s3_min0",     bus.o_minutes, 0);
        bus.btn_inc = 1'b1;
        step();
        check("s3_after_rise", bus.o_minutes, 1);
        repeat (7) step();
        check("s3_before_dly", bus.o_minutes, 1);
        step();
        check("s3_first_tick", bus.o_minutes, 2);
        repeat (3) step();
        check("s3_second_tick", bus.o_minutes, 3);
        repeat (8) step();
        bus.btn_inc = 1'b0;
        step();
        check("s3_final", bus.o_minutes, 5);
        check("s3_mode_still_min", bus.o_mode, 2);
        press_mode();
        step();
        check("s3_load_count", load_cnt, 3);
        check("s3_tk_min",     tk_min,   5);

        // Inactivity timeout from SET_HR with blink
        bus.cur_hours   = 5'd7;
        bus.cur_minutes = 6'd30;
        loads_before    = load_cnt;
        bus.btn_mode    = 1'b1;
        step();
        bus.btn_mode    = 1'b0;
        check("s4_mode_hr", bus.o_mode,  1);
        check("s4_blink0",  bus.o_blink, 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k < 20) begin
                check("s4_mode_wait", bus.o_mode,  1);
                check("s4_blink",     bus.o_blink, ((k / 4) % 2 == 0) ? 1 : 0);
            end else begin
                check("s4_mode_abort", bus.o_mode,  0);
                check("s4_blink_off",  bus.o_blink, 0);
            end
        end
        check("s4_hours_kept", bus.o_hours,   7);
        check("s4_min_kept",   bus.o_minutes, 30);
        check("s4_no_load",    load_cnt, loads_before);

        // Async reset in SET_MIN just before the commit press
        bus.cur_hours   = 5'd9;
        bus.cur_minutes = 6'd20;
        press_mode();
        press_mode();
        press_inc(1);
        check("s5_min", bus.o_minutes, 21);
        #3;
        rst = 1'b0;
        #1;
        check("s5_async_mode",  bus.o_mode,    0);
        check("s5_async_hours", bus.o_hours,   0);
        check("s5_async_min",   bus.o_minutes, 0);
        check("s5_async_load",  bus.o_load,    0);
        bus.btn_mode = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        check("s5_held_no_rise", bus.o_mode, 0);
        bus.btn_mode = 1'b0;
        repeat (2) step();
        check("s5_mode_run",   bus.o_mode, 0);
        check("s5_no_load",    load_cnt, loads_before);
        check("no_double_load", load_dbl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Button-driven time-setting controller for the digital clock. It sits between the debounced user buttons and the hours/minutes timekeeping counter. It sequences run → set-hours → set-minutes → commit, and holds shadow hour/minute values that the user edits. On commit it pulses the timekeeper's load enable for one cycle so the edited time is written. Edits abort on inactivity timeout, and a held increment button auto-repeats.

## Interface
- TIMEOUT, 2500, idle cycles in a set state before abort to RUN (≥2)
- REPEAT_DLY, 500, cycles btn_inc must be held before the first auto-repeat (≥2)
- REPEAT_PER, 100, cycles between subsequent auto-repeats (≥1)
- BLINK_PER, 50, cycles per blink half-period in set states (≥1)
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- btn_mode  in  1  debounced mode button, synchronous to clk, level
- btn_inc  in  1  debounced increment button, synchronous to clk, level
- cur_hours  in  5  live hours from timekeeper, 0..23
- cur_minutes  in  6  live minutes from timekeeper, 0..59
- o_load  out  1  one-cycle load pulse; drives timekeeper normal_en
- o_hours  out  5  shadow hours; drives timekeeper i_hours
- o_minutes  out  6  shadow minutes; drives timekeeper i_minutes
- o_mode  out  2  state: 00 RUN, 01 SET_HR, 10 SET_MIN, 11 COMMIT
- o_blink  out  1  display blink gate for the field being edited

## Operation
- Edge detect: register btn_mode and btn_inc each cycle (reset 0). rise = btn & ~btn_q. A level held through reset does not produce a rise until it is released and pressed again.
- RUN:
  - mode rise → SET_HR. On the same edge, copy cur_hours/cur_minutes into the shadow registers.
  - inc ignored.
- SET_HR:
  - inc rise or auto-repeat tick → o_hours += 1, wrapping 23→0.
  - mode rise → SET_MIN.
- SET_MIN:
  - inc rise or tick → o_minutes += 1, wrapping 59→0.
  - mode rise → COMMIT.
- COMMIT: o_load=1 for exactly this one cycle, then unconditionally → RUN. Buttons are ignored.
- Simultaneous mode rise and inc rise: mode wins; the increment is dropped.
- Auto-repeat (set states only):
  - The hold counter clears on inc rise, and whenever btn_inc=0 or the state changes.
  - While btn_inc stays high, the first tick fires when the counter reaches REPEAT_DLY cycles after the rise. Later ticks fire every REPEAT_PER cycles.
  - A tick is a single increment, same as a rise.
- Timeout (set states only):
  - The idle counter clears on state entry, on any rise, and on any tick.
  - Reaching TIMEOUT-1 → RUN with no load pulse. Shadow values are retained but not committed.
- Blink:
  - o_blink=1 on entry to SET_HR/SET_MIN, then toggles every BLINK_PER cycles.
  - The blink counter restarts on each increment, so the field is shown solid while it is edited.
  - o_blink=0 in RUN and COMMIT.
- Shadow registers stay unchanged in RUN except at the capture edge. The timekeeper only sees them while o_load=1.
- Counter widths: use $clog2 of each parameter. Counters saturate and never wrap.

## Timing
- Reset values: o_mode=00, o_load=0, o_hours=0, o_minutes=0, o_blink=0, all internal counters and button registers 0.
- Reset is asynchronous. Asserting it mid-edit or during COMMIT returns the block to RUN immediately, and no load is issued.
- Latency: a button first sampled high at edge N produces its state or value change visible after edge N; there is no extra pipeline.
- Load latency: the mode rise in SET_MIN at edge N drives o_load=1 between edges N and N+1, and the timekeeper captures at N+1. o_mode returns to 00 after N+1.
- Per edit session there is at most one o_load pulse. o_load is never high in two consecutive cycles.
- Wrap boundaries: hours 23→0 and minutes 59→0. The other field is not carried.

## Test plan
- Reset with btn_mode held high, then release → o_mode=00, all outputs 0, and no state change until a fresh rise.
- With cur=13:45: mode, inc×2, mode, inc×16, mode → o_hours=15, o_minutes=1 (45+16 wraps past 59); o_load high for exactly 1 cycle; the timekeeper reads 15:01; o_mode=00.
- SET_HR from 22: inc×3 → 23, 0, 1. Simultaneous mode+inc rise → o_mode=10 with o_hours unchanged.
- REPEAT_DLY=8, REPEAT_PER=3: hold inc for 20 cycles in SET_MIN starting from 0 → increments at cycles 0, 8, 11, 14, 17 → o_minutes=5.
- TIMEOUT=20: enter SET_HR, then idle → o_mode=00 after 20 cycles, o_load never asserts, and o_blink toggles every BLINK_PER until the exit.
- Assert rst in SET_MIN, one cycle before the commit press → immediate o_mode=00, shadow registers 0, and no o_load pulse.
